// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus between the memory-stage controller and the data memory.
interface mem_stage_ctrl_if #(
   parameter int unsigned DATA_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores over a variable-latency memory handshake,
// stalls the pipeline while an access is outstanding and registers the MEM/WB fields.
module mem_stage_ctrl #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_ADDR_W = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_MemRead,
   input  logic                  in_MemWrite,
   input  logic                  in_Branch,
   input  logic                  in_Zero,
   input  logic [DATA_W-1:0]     in_BranchTarget,
   input  logic [DATA_W-1:0]     in_ALUResult,
   input  logic [DATA_W-1:0]     in_Write_Data,
   input  logic                  in_MemtoReg,
   input  logic                  in_RegWrite,
   input  logic [REG_ADDR_W-1:0] in_WriteRegister,
   mem_stage_ctrl_if.master      mem_bus,
   output logic                  O_Stall,
   output logic                  O_PCSrc,
   output logic [DATA_W-1:0]     O_BranchTarget,
   output logic [DATA_W-1:0]     O_ReadData,
   output logic [DATA_W-1:0]     O_ALUResult,
   output logic                  O_MemtoReg,
   output logic                  O_RegWrite,
   output logic [REG_ADDR_W-1:0] O_WriteRegister,
   output logic                  O_MemError
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [DATA_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   // write-back fields parked while the access is outstanding
   logic [DATA_W-1:0]     wb_alu_q, wb_alu_d;
   logic                  wb_mtr_q, wb_mtr_d;
   logic                  wb_rw_q, wb_rw_d;
   logic [REG_ADDR_W-1:0] wb_wreg_q, wb_wreg_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [DATA_W-1:0]     alu_q, alu_d;
   logic                  mtr_q, mtr_d;
   logic                  rw_q, rw_d;
   logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
   logic                  err_q, err_d;

   logic mem_op_c;
   logic stall_c;

   assign mem_op_c = in_MemRead | in_MemWrite;
   assign stall_c  = (state_q == ACCESS) | ((state_q == IDLE) & mem_op_c);

   // State and output registers; the pipeline registers update on the falling edge.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wb_alu_q  <= '0;
         wb_mtr_q  <= 1'b0;
         wb_rw_q   <= 1'b0;
         wb_wreg_q <= '0;
         rdata_q   <= '0;
         alu_q     <= '0;
         mtr_q     <= 1'b0;
         rw_q      <= 1'b0;
         wreg_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wb_alu_q  <= wb_alu_d;
         wb_mtr_q  <= wb_mtr_d;
         wb_rw_q   <= wb_rw_d;
         wb_wreg_q <= wb_wreg_d;
         rdata_q   <= rdata_d;
         alu_q     <= alu_d;
         mtr_q     <= mtr_d;
         rw_q      <= rw_d;
         wreg_q    <= wreg_d;
         err_q     <= err_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wb_alu_d  = wb_alu_q;
      wb_mtr_d  = wb_mtr_q;
      wb_rw_d   = wb_rw_q;
      wb_wreg_d = wb_wreg_q;
      rdata_d   = rdata_q;
      alu_d     = alu_q;
      mtr_d     = mtr_q;
      rw_d      = rw_q;
      wreg_d    = wreg_q;
      err_d     = err_q;

      case (state_q)
         IDLE: begin
            if (mem_op_c) begin
               addr_d    = in_ALUResult;
               wdata_d   = in_Write_Data;
               we_d      = in_MemWrite;
               wb_alu_d  = in_ALUResult;
               wb_mtr_d  = in_MemtoReg;
               wb_rw_d   = in_RegWrite;
               wb_wreg_d = in_WriteRegister;
               req_d     = 1'b1;
               cnt_d     = '0;
               rw_d      = 1'b0;
               state_d   = ACCESS;
            end else begin
               alu_d   = in_ALUResult;
               mtr_d   = in_MemtoReg;
               rw_d    = in_RegWrite;
               wreg_d  = in_WriteRegister;
               rdata_d = '0;
            end
         end
         ACCESS: begin
            if (mem_bus.mem_ready) begin
               rdata_d = we_q ? '0 : mem_bus.mem_rdata;
               alu_d   = wb_alu_q;
               mtr_d   = wb_mtr_q;
               rw_d    = wb_rw_q;
               wreg_d  = wb_wreg_q;
               req_d   = 1'b0;
               state_d = IDLE;
            end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
               // this edge is the TIMEOUT-th without ready: give up on the access
               cnt_d   = cnt_q + CNT_W'(1);
               req_d   = 1'b0;
               err_d   = 1'b1;
               rw_d    = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               rw_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_bus.mem_req   = req_q;
   assign mem_bus.mem_we    = we_q;
   assign mem_bus.mem_addr  = addr_q;
   assign mem_bus.mem_wdata = wdata_q;

   assign O_Stall         = stall_c;
   assign O_PCSrc         = in_Branch & in_Zero & ~stall_c;
   assign O_BranchTarget  = in_BranchTarget;
   assign O_ReadData      = rdata_q;
   assign O_ALUResult     = alu_q;
   assign O_MemtoReg      = mtr_q;
   assign O_RegWrite      = rw_q;
   assign O_WriteRegister = wreg_q;
   assign O_MemError      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a scoreboard checks every write-back against queued expectations.
module tb_mem_stage_ctrl;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        br;
      logic        zero;
      logic [15:0] tgt;
      logic [15:0] alu;
      logic [15:0] wdata;
      logic        mtr;
      logic        rw;
      logic [2:0]  wreg;
   } op_t;

   typedef struct packed {
      logic [15:0] alu;
      logic [15:0] rdata;
      logic        mtr;
      logic [2:0]  wreg;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_MemRead, in_MemWrite, in_Branch, in_Zero;
   logic [15:0] in_BranchTarget, in_ALUResult, in_Write_Data;
   logic        in_MemtoReg, in_RegWrite;
   logic [2:0]  in_WriteRegister;
   logic        O_Stall, O_PCSrc, O_MemtoReg, O_RegWrite, O_MemError;
   logic [15:0] O_BranchTarget, O_ReadData, O_ALUResult;
   logic [2:0]  O_WriteRegister;

   int checks = 0;
   int failures = 0;
   wb_t exp_q[$];

   int          mem_delay = 0;
   logic [15:0] rdata_val = 16'h0000;
   logic        ready_force = 1'b0;
   int          acc_cnt = 0;

   mem_stage_ctrl_if #(.DATA_W(16)) mem_bus ();

   mem_stage_ctrl #(.DATA_W(16), .REG_ADDR_W(3), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
      .in_Branch(in_Branch), .in_Zero(in_Zero),
      .in_BranchTarget(in_BranchTarget), .in_ALUResult(in_ALUResult),
      .in_Write_Data(in_Write_Data), .in_MemtoReg(in_MemtoReg),
      .in_RegWrite(in_RegWrite), .in_WriteRegister(in_WriteRegister),
      .mem_bus(mem_bus),
      .O_Stall(O_Stall), .O_PCSrc(O_PCSrc), .O_BranchTarget(O_BranchTarget),
      .O_ReadData(O_ReadData), .O_ALUResult(O_ALUResult),
      .O_MemtoReg(O_MemtoReg), .O_RegWrite(O_RegWrite),
      .O_WriteRegister(O_WriteRegister), .O_MemError(O_MemError)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic op_t mk_op(input logic rd, input logic wr, input logic [15:0] alu,
                                 input logic [15:0] wdata, input logic mtr, input logic rw,
                                 input logic [2:0] wreg);
      op_t o;
      o.rd = rd; o.wr = wr; o.br = 1'b0; o.zero = 1'b0; o.tgt = 16'h0000;
      o.alu = alu; o.wdata = wdata; o.mtr = mtr; o.rw = rw; o.wreg = wreg;
      return o;
   endfunction

   task automatic apply(input op_t o);
      in_MemRead       = o.rd;
      in_MemWrite      = o.wr;
      in_Branch        = o.br;
      in_Zero          = o.zero;
      in_BranchTarget  = o.tgt;
      in_ALUResult     = o.alu;
      in_Write_Data    = o.wdata;
      in_MemtoReg      = o.mtr;
      in_RegWrite      = o.rw;
      in_WriteRegister = o.wreg;
   endtask

   // Present one instruction, hold it while stalled, then present a nop cycle.
   task automatic run_op(input string nm, input op_t o, input int delay, input logic [15:0] rdata,
                         input int exp_stall, input int exp_acc, input logic exp_we);
      int stalls = 0;
      int accs = 0;
      bit done = 0;
      mem_delay = delay;
      rdata_val = rdata;
      apply(o);
      @(posedge clk);
      if (O_Stall) stalls++;
      @(negedge clk); #1;
      if (o.rd || o.wr) begin
         for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            if (O_Stall) stalls++;
            if (mem_bus.mem_req) begin
               accs++;
               check({nm, "_addr"}, 32'(mem_bus.mem_addr), 32'(o.alu));
               check({nm, "_we"}, 32'(mem_bus.mem_we), 32'(exp_we));
               if (exp_we) check({nm, "_wdata"}, 32'(mem_bus.mem_wdata), 32'(o.wdata));
            end
            @(negedge clk); #1;
            if (!mem_bus.mem_req) done = 1;
         end
         if (!done) check({nm, "_completion_bound"}, 32'(0), 32'(1));
      end
      apply(mk_op(0, 0, 16'h0000, 16'h0000, 0, 0, 3'd0));
      @(posedge clk);
      check({nm, "_stall_released"}, 32'(O_Stall), 32'(0));
      check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
      check({nm, "_access_cycles"}, 32'(accs), 32'(exp_acc));
      @(negedge clk); #1;
   endtask

   // Memory model: ready on the delay-th ACCESS cycle (0 = never), garbage data otherwise.
   always @(posedge clk) begin
      logic rdy;
      if (mem_bus.mem_req) begin
         acc_cnt++;
         rdy = ready_force || (mem_delay != 0 && acc_cnt == mem_delay);
      end else begin
         acc_cnt = 0;
         rdy = ready_force;
      end
      mem_bus.mem_ready = rdy;
      mem_bus.mem_rdata = rdy ? rdata_val : 16'hDEAD;
   end

   // Scoreboard monitor: every write-back must match the oldest expectation.
   always @(posedge clk) begin
      if (!rst && O_RegWrite) begin
         if (exp_q.size() == 0) begin
            check("wb_unexpected", 32'(O_RegWrite), 32'(0));
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("wb_alu", 32'(O_ALUResult), 32'(e.alu));
            check("wb_rdata", 32'(O_ReadData), 32'(e.rdata));
            check("wb_memtoreg", 32'(O_MemtoReg), 32'(e.mtr));
            check("wb_wreg", 32'(O_WriteRegister), 32'(e.wreg));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      op_t o;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 16'h0000;
      apply(mk_op(0, 0, 16'h0000, 16'h0000, 0, 0, 3'd0));
      rst = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      rst = 1'b0;

      // Reset state
      @(posedge clk);
      check("rst_req", 32'(mem_bus.mem_req), 32'(0));
      check("rst_we", 32'(mem_bus.mem_we), 32'(0));
      check("rst_addr", 32'(mem_bus.mem_addr), 32'(0));
      check("rst_wdata", 32'(mem_bus.mem_wdata), 32'(0));
      check("rst_stall", 32'(O_Stall), 32'(0));
      check("rst_regwrite", 32'(O_RegWrite), 32'(0));
      check("rst_memerror", 32'(O_MemError), 32'(0));
      check("rst_alu", 32'(O_ALUResult), 32'(0));
      @(negedge clk); #1;

      // ALU ops
      exp_q.push_back('{alu: 16'h0042, rdata: 16'h0000, mtr: 1'b0, wreg: 3'd3});
      run_op("alu1", mk_op(0, 0, 16'h0042, 16'h0000, 0, 1, 3'd3), 0, 16'h0000, 0, 0, 0);
      exp_q.push_back('{alu: 16'hA5A5, rdata: 16'h0000, mtr: 1'b0, wreg: 3'd7});
      run_op("alu2", mk_op(0, 0, 16'hA5A5, 16'hFFFF, 0, 1, 3'd7), 0, 16'h0000, 0, 0, 0);

      // Load, ready on the 3rd ACCESS cycle
      exp_q.push_back('{alu: 16'h0010, rdata: 16'hBEEF, mtr: 1'b1, wreg: 3'd5});
      run_op("load3", mk_op(1, 0, 16'h0010, 16'h0000, 1, 1, 3'd5), 3, 16'hBEEF, 4, 3, 0);

      // Store, ready immediately
      run_op("store", mk_op(0, 1, 16'h0020, 16'h1234, 0, 0, 3'd0), 1, 16'h7777, 2, 1, 1);

      // Read and write both set: write wins, read data forced to 0
      exp_q.push_back('{alu: 16'h0030, rdata: 16'h0000, mtr: 1'b0, wreg: 3'd2});
      run_op("rdwr", mk_op(1, 1, 16'h0030, 16'h5555, 0, 1, 3'd2), 2, 16'h9999, 3, 2, 1);

      // Branch resolution is combinational
      o = mk_op(0, 0, 16'h0000, 16'h0000, 0, 0, 3'd0);
      o.br = 1'b1; o.zero = 1'b1; o.tgt = 16'h0100;
      apply(o);
      #1;
      check("br_taken_pcsrc", 32'(O_PCSrc), 32'(1));
      check("br_target", 32'(O_BranchTarget), 32'(16'h0100));
      in_Zero = 1'b0;
      #1;
      check("br_not_taken_pcsrc", 32'(O_PCSrc), 32'(0));
      run_op("branch", o, 0, 16'h0000, 0, 0, 0);

      // Timeout: ready never comes
      run_op("timeout", mk_op(1, 0, 16'h0040, 16'h0000, 1, 1, 3'd4), 0, 16'h0000, 16, 15, 0);
      check("timeout_memerror", 32'(O_MemError), 32'(1));
      check("timeout_regwrite", 32'(O_RegWrite), 32'(0));

      // Late ready in IDLE is ignored
      ready_force = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      ready_force = 1'b0;
      @(posedge clk);
      check("late_ready_req", 32'(mem_bus.mem_req), 32'(0));
      check("late_ready_stall", 32'(O_Stall), 32'(0));
      check("late_ready_regwrite", 32'(O_RegWrite), 32'(0));
      check("late_ready_memerror", 32'(O_MemError), 32'(1));
      @(negedge clk); #1;

      // Pipeline keeps working; the error stays sticky
      exp_q.push_back('{alu: 16'h1111, rdata: 16'h0000, mtr: 1'b0, wreg: 3'd1});
      run_op("alu_after_err", mk_op(0, 0, 16'h1111, 16'h0000, 0, 1, 3'd1), 0, 16'h0000, 0, 0, 0);
      check("memerror_sticky", 32'(O_MemError), 32'(1));

      // Reset during the 2nd ACCESS cycle
      mem_delay = 0;
      apply(mk_op(1, 0, 16'h0050, 16'h0000, 1, 1, 3'd6));
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      apply(mk_op(0, 0, 16'h0000, 16'h0000, 0, 0, 3'd0));
      @(posedge clk);
      check("midrst_req", 32'(mem_bus.mem_req), 32'(0));
      check("midrst_stall", 32'(O_Stall), 32'(0));
      check("midrst_memerror", 32'(O_MemError), 32'(0));
      check("midrst_regwrite", 32'(O_RegWrite), 32'(0));
      check("midrst_addr", 32'(mem_bus.mem_addr), 32'(0));
      check("midrst_alu", 32'(O_ALUResult), 32'(0));
      @(negedge clk); #1;

      // Normal operation after reset
      exp_q.push_back('{alu: 16'h0060, rdata: 16'hC0DE, mtr: 1'b1, wreg: 3'd2});
      run_op("load1", mk_op(1, 0, 16'h0060, 16'h0000, 1, 1, 3'd2), 1, 16'hC0DE, 2, 1, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller sitting directly downstream of the EX/MEM pipeline register in the 16-bit MIPS datapath.
It consumes the EX/MEM control and data fields, runs the load/store against the data memory over a req/ready handshake with variable latency, and resolves the branch (PCSrc, target).
It stalls the upstream pipeline while an access is outstanding and registers the MEM/WB fields for the write-back stage.

Parameters:
DATA_W, 16, datapath and memory word width
REG_ADDR_W, 3, register-file address width
TIMEOUT, 15, maximum ACCESS cycles without mem_ready before the access is aborted (1..255)

Ports:
clk  in  1  clock; all state updates on the falling edge, as for the pipeline registers
rst  in  1  synchronous, active-high reset
in_MemRead  in  1  load request from EX/MEM
in_MemWrite  in  1  store request from EX/MEM
in_Branch  in  1  branch instruction flag
in_Zero  in  1  ALU zero flag
in_BranchTarget  in  DATA_W  PC+2+immediate
in_ALUResult  in  DATA_W  memory address, or result for non-memory instructions
in_Write_Data  in  DATA_W  store data
in_MemtoReg  in  1  write-back select
in_RegWrite  in  1  write-back enable
in_WriteRegister  in  REG_ADDR_W  destination register
mem_req  out  1  memory request, held until completion or abort
mem_we  out  1  1 = write, 0 = read
mem_addr  out  DATA_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  access complete this cycle
O_Stall  out  1  upstream must hold EX/MEM contents
O_PCSrc  out  1  take branch
O_BranchTarget  out  DATA_W  branch target to the PC mux
O_ReadData  out  DATA_W  MEM/WB load data
O_ALUResult  out  DATA_W  MEM/WB ALU result
O_MemtoReg  out  1  MEM/WB select
O_RegWrite  out  1  MEM/WB write enable
O_WriteRegister  out  REG_ADDR_W  MEM/WB destination
O_MemError  out  1  sticky timeout flag

Behaviour:
- Reset on a clk edge with rst=1:
  - state=IDLE, timeout counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, all O_* registers and O_MemError = 0.
  - rst has priority over every other event.
- FSM states: IDLE, ACCESS.
- IDLE, no memory operation (in_MemRead=in_MemWrite=0):
  - At the edge, register O_ALUResult, O_MemtoReg, O_RegWrite and O_WriteRegister from the inputs; O_ReadData=0.
  - Latency 1 edge; no stall.
- IDLE, with in_MemRead or in_MemWrite:
  - O_Stall=1 combinationally in the same cycle.
  - At the edge:
    - Latch mem_addr=in_ALUResult, mem_wdata=in_Write_Data.
    - mem_we=in_MemWrite; if both MemRead and MemWrite are set, the write wins.
    - Latch the write-back fields and set mem_req=1, counter=0, then go to ACCESS.
    - Emit a bubble: O_RegWrite=0.
- ACCESS:
  - O_Stall=1 until the completing edge.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - Edge with mem_ready=1:
    - For a read, O_ReadData=mem_rdata; for a write, O_ReadData=0.
    - Release the latched O_ALUResult, O_MemtoReg, O_RegWrite and O_WriteRegister.
    - mem_req=0, go to IDLE.
    - O_Stall falls after this edge, so the next instruction is presented in the following cycle.
  - Edge with mem_ready=0: counter+1, and O_RegWrite=0 (bubble).
  - When the counter reaches TIMEOUT with no ready:
    - Abort: mem_req=0, O_MemError=1, O_RegWrite=0 for the aborted instruction, go to IDLE.
- mem_ready is ignored in IDLE, including a late ready after an abort or reset.
- Total load/store latency is 1 + N edges, where N is the number of ACCESS cycles up to and including the one with ready.
- Branch resolution:
  - O_PCSrc = in_Branch & in_Zero & ~O_Stall, combinational.
  - O_BranchTarget = in_BranchTarget, combinational.
  - Branch instructions never issue memory operations.
- O_MemError clears only on rst.
- Reset during ACCESS abandons the transfer; mem_req is 0 after that edge.

Test Plan:
- ALU op: in_ALUResult=16'h0042, RegWrite=1, WriteRegister=3 -> next edge O_ALUResult=0042, O_RegWrite=1, O_WriteRegister=3; O_Stall never high.
- Load with 3-cycle memory: MemRead, addr 16'h0010, mem_rdata=16'hBEEF on the 3rd ACCESS cycle -> O_Stall high 4 cycles; mem_addr=0010, mem_we=0; then O_ReadData=BEEF, O_MemtoReg=1, O_RegWrite=1.
- Store with mem_ready held high: MemWrite, addr 16'h0020, data 16'h1234 -> mem_we=1, mem_wdata=1234 for exactly one ACCESS cycle; O_RegWrite=0; O_Stall high 2 cycles.
- Branch: Branch=1, Zero=1, target 16'h0100 -> O_PCSrc=1, O_BranchTarget=0100 the same cycle; with Zero=0 -> O_PCSrc=0.
- Timeout (TIMEOUT=15): load, mem_ready never asserted -> mem_req drops after 15 ACCESS edges; O_MemError=1 and stays set; O_RegWrite=0; a later mem_ready pulse has no effect.
- Reset mid-access: rst on the 2nd ACCESS cycle -> next edge mem_req=0, O_Stall=0, all outputs 0, state IDLE.
